// File: rtl/hdmi_video_timing_if.sv
// rtl/hdmi_video_timing_if.sv - raster timing bundle from the timing generator to the pattern source and HDMI TX
interface hdmi_video_timing_if;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        line_start;
    logic        frame_start;
    logic        running;

    modport master (
        output hsync, vsync, de, pix_x, pix_y, line_start, frame_start, running
    );

    modport slave (
        input  hsync, vsync, de, pix_x, pix_y, line_start, frame_start, running
    );
endinterface

// File: rtl/hdmi_video_timing.sv
// rtl/hdmi_video_timing.sv - 720p60 raster timing generator gated on a synchronized PLL lock
module hdmi_video_timing #(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 110,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 220,
    parameter int V_ACTIVE  = 720,
    parameter int V_FP      = 5,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter bit H_POL     = 1'b1,
    parameter bit V_POL     = 1'b1,
    parameter int LOCK_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    hdmi_video_timing_if.master vid_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
    localparam logic [10:0] H_HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0]  V_VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [7:0]  LW        = 8'(LOCK_WAIT);

    typedef enum logic {ST_WAIT_LOCK, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        ok_q, ok_d;
    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [11:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic        ls_q, ls_d, fs_q, fs_d, run_q, run_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b0;
            pix_x_q <= '0;
            pix_y_q <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            run_q   <= run_d;
        end
    end

    // The count==LOCK_WAIT compare is registered into ok_q so RUN entry is
    // decided from a flop; RUN still needs lock present on the entry edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        ok_d    = 1'b0;
        h_d     = '0;
        v_d     = '0;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                if (sync2_q) begin
                    cnt_d = (cnt_q == LW) ? cnt_q : cnt_q + 8'd1;
                end
                ok_d = sync2_q && (cnt_q == LW);
                if (ok_q && sync2_q) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    ok_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (!sync2_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (h_q == H_LAST) begin
                    v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
                end else begin
                    h_d = h_q + 11'd1;
                    v_d = v_q;
                end
            end
            default: state_d = ST_WAIT_LOCK;
        endcase

        // Outputs decode the position being loaded so they line up with the counters.
        run_d   = (state_d == ST_RUN);
        de_d    = run_d && (h_d < H_ACT) && (v_d < V_ACT);
        pix_x_d = de_d ? {1'b0, h_d} : '0;
        pix_y_d = de_d ? {2'b0, v_d} : '0;
        hsync_d = (run_d && (h_d >= H_HS_BEG) && (h_d < H_HS_END)) ? H_POL : ~H_POL;
        vsync_d = (run_d && (v_d >= V_VS_BEG) && (v_d < V_VS_END)) ? V_POL : ~V_POL;
        ls_d    = run_d && (h_d == '0);
        fs_d    = run_d && (h_d == '0) && (v_d == '0);
    end

    assign vid_o.hsync       = hsync_q;
    assign vid_o.vsync       = vsync_q;
    assign vid_o.de          = de_q;
    assign vid_o.pix_x       = pix_x_q;
    assign vid_o.pix_y       = pix_y_q;
    assign vid_o.line_start  = ls_q;
    assign vid_o.frame_start = fs_q;
    assign vid_o.running     = run_q;
endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb/tb_hdmi_video_timing.sv - scoreboard bench for the raster timing generator on a reduced raster
module tb_hdmi_video_timing;
    localparam int HA = 20, HFP = 4, HS = 3, HB = 5;
    localparam int VA = 8,  VFP = 2, VS = 2, VB = 3;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VT = VA + VFP + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b0;

    hdmi_video_timing_if vif();

    hdmi_video_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b1), .LOCK_WAIT(LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .vid_o     (vif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        running;
        logic        frame_start;
        logic        line_start;
        logic        de;
        logic        hsync;
        logic        vsync;
        logic [11:0] pix_x;
        logic [11:0] pix_y;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_tmo = 1'b0;
    bit   tmo_done = 1'b0;

    function automatic obs_t expect_at(bit run, int p);
        obs_t e;
        int h, v;
        e = '0;
        if (run) begin
            h = p % HT;
            v = p / HT;
            e.running     = 1'b1;
            e.line_start  = (h == 0);
            e.frame_start = (p == 0);
            e.de          = (h < HA) && (v < VA);
            if (e.de) begin
                e.pix_x = 12'(h);
                e.pix_y = 12'(v);
            end
            e.hsync = (h >= HA + HFP) && (h < HA + HFP + HS);
            e.vsync = (v >= VA + VFP) && (v < VA + VFP + VS);
        end
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.running     = vif.running;
        a.frame_start = vif.frame_start;
        a.line_start  = vif.line_start;
        a.de          = vif.de;
        a.hsync       = vif.hsync;
        a.vsync       = vif.vsync;
        a.pix_x       = vif.pix_x;
        a.pix_y       = vif.pix_y;
        return a;
    endfunction

    // Reference: raster runs while the lock seen two edges ago holds; it starts
    // once LW+2 consecutive lock samples are seen, at linear frame position 0.
    bit m_run = 1'b0;
    int m_pos = 0;
    int m_len = 0;
    bit m_samp[$];

    always @(posedge clk) begin
        bit s_old;
        if (rst) begin
            m_samp.delete();
            m_samp.push_back(1'b0);
            m_samp.push_back(1'b0);
            m_run = 1'b0;
            m_pos = 0;
            m_len = 0;
        end else begin
            s_old = m_samp.pop_front();
            m_samp.push_back(pll_locked);
            m_len = s_old ? m_len + 1 : 0;
            if (m_run) begin
                if (!s_old) begin
                    m_run = 1'b0;
                    m_pos = 0;
                end else begin
                    m_pos = (m_pos + 1) % FRAME;
                end
            end else if (m_len == LW + 2) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end
        exp_q.push_back(expect_at(m_run, m_pos));
    end

    obs_t act, want;
    bit   fs_seen = 1'b0;
    int   since_fs = 0, de_cnt = 0, ls_cnt = 0, hs_len = 0, vs_len = 0;

    initial begin
        forever begin
            @(negedge clk or posedge rst);
            if (clk) begin
                #1;
                act  = sample();
                want = expect_at(1'b0, 0);
                checks++;
                if (act !== want) begin
                    errors++;
                    $display("FAIL rst_async got %h want %h", act, want);
                end
                exp_q.delete();
                fs_seen = 1'b0;
                hs_len  = 0;
                vs_len  = 0;
            end else begin
                if (stim_tmo && !tmo_done) begin
                    tmo_done = 1'b1;
                    checks++;
                    errors++;
                    $display("FAIL wait_timeout got expired want raster position reached");
                end
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    act  = sample();
                    checks++;
                    if (act !== want) begin
                        errors++;
                        $display("FAIL outputs t=%0t got %h want %h", $time, act, want);
                    end
                    if (!act.running) begin
                        fs_seen = 1'b0;
                        hs_len  = 0;
                        vs_len  = 0;
                    end else begin
                        if (act.frame_start) begin
                            if (fs_seen) begin
                                checks++;
                                if (since_fs != FRAME || de_cnt != HA * VA || ls_cnt != VT) begin
                                    errors++;
                                    $display("FAIL frame_counts got period %0d de %0d lines %0d want %0d %0d %0d",
                                             since_fs, de_cnt, ls_cnt, FRAME, HA * VA, VT);
                                end
                            end
                            fs_seen  = 1'b1;
                            since_fs = 0;
                            de_cnt   = 0;
                            ls_cnt   = 0;
                        end
                        since_fs++;
                        de_cnt += int'(act.de);
                        ls_cnt += int'(act.line_start);
                        if (act.hsync) hs_len++;
                        else if (hs_len != 0) begin
                            checks++;
                            if (hs_len != HS) begin
                                errors++;
                                $display("FAIL hsync_width got %0d want %0d", hs_len, HS);
                            end
                            hs_len = 0;
                        end
                        if (act.vsync) vs_len++;
                        else if (vs_len != 0) begin
                            checks++;
                            if (vs_len != VS * HT) begin
                                errors++;
                                $display("FAIL vsync_width got %0d want %0d", vs_len, VS * HT);
                            end
                            vs_len = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic wait_pos(input int p, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_run && m_pos == p) return;
        end
        stim_tmo = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pll_locked = 1'b1;
        repeat (2 * FRAME + 40) @(negedge clk);

        wait_pos(3 * HT + 6, FRAME + 10);
        pll_locked = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        pll_locked = 1'b1;
        repeat (FRAME + 40) @(negedge clk);

        pll_locked = 1'b0;
        repeat (4) @(negedge clk);
        pll_locked = 1'b1;
        repeat (12) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        repeat (60) @(negedge clk);

        for (int k = 0; k < 25; k++) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        pll_locked = 1'b1;
        wait_pos($urandom_range(0, FRAME - 1), 2 * FRAME + 60);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (LW + 40) @(negedge clk);

        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
